// File: rtl/aether_engine_pkg.sv
// ---------------------------------------------------------------------------
// aether_engine_pkg
// Shared definitions for the engine command path: opcodes, selector codes for
// each opcode, the packed 24-bit command layout and the encoder state type.
// No ports; imported by the encoder and the legality checker.
// ---------------------------------------------------------------------------
package aether_engine_pkg;

    // Opcodes carried in cmd[23:20]
    localparam logic [3:0] NOP        = 4'h0;
    localparam logic [3:0] RESET      = 4'h1;
    localparam logic [3:0] WRITE_REG  = 4'h2;
    localparam logic [3:0] READ_REG   = 4'h3;
    localparam logic [3:0] START_TASK = 4'h4;

    // Reset types (selector of RESET)
    localparam logic [3:0] RST_ALL          = 4'h0;
    localparam logic [3:0] RST_CONV         = 4'h1;
    localparam logic [3:0] RST_CONV_WEIGHTS = 4'h2;
    localparam logic [3:0] TASK_RAM         = 4'h3;

    // Task codes (selector of START_TASK)
    localparam logic [3:0] LOAD_CONV_WEIGHTS = 4'h0;
    localparam logic [3:0] RUN_CONV          = 4'h1;
    localparam logic [3:0] LOAD_INPUT        = 4'h2;
    localparam logic [3:0] WRITE_TO_MEM      = 4'h6;
    localparam logic [3:0] READ_FROM_MEM     = 4'h7;

    // Register addresses (selector of WRITE_REG / READ_REG)
    localparam logic [3:0] REG_0 = 4'h0;
    localparam logic [3:0] REG_1 = 4'h1;
    localparam logic [3:0] REG_2 = 4'h2;
    localparam logic [3:0] REG_3 = 4'h3;
    localparam logic [3:0] REG_4 = 4'h4;
    localparam logic [3:0] REG_5 = 4'h5;
    localparam logic [3:0] REG_6 = 4'h6;
    localparam logic [3:0] REG_7 = 4'h7;
    localparam logic [3:0] REG_8 = 4'h8;
    localparam logic [3:0] REG_E = 4'hE;
    localparam logic [3:0] REG_F = 4'hF;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  sel;
        logic [15:0] payload;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        GAP
    } state_t;

endpackage

// File: rtl/aether_engine_cmd_legal.sv
// ---------------------------------------------------------------------------
// aether_engine_cmd_legal
// Combinational check of whether the decoder accepts an op/sel pair.
// Ports:
//   i_op    - 4-bit opcode
//   i_sel   - 4-bit selector (reset type / register address / task code)
//   o_legal - 1 when the decoder would act on this command
// ---------------------------------------------------------------------------
module aether_engine_cmd_legal
    import aether_engine_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic [3:0] i_sel,
    output logic       o_legal
);

    // Each opcode has its own set of meaningful selectors; unknown opcodes
    // are never legal.
    always_comb begin
        o_legal = 1'b0;
        case (i_op)
            NOP:        o_legal = 1'b1;
            RESET:      o_legal = (i_sel <= TASK_RAM);
            WRITE_REG:  o_legal = ((i_sel >= REG_1) && (i_sel <= REG_6)) || (i_sel == REG_E);
            READ_REG:   o_legal = (i_sel <= REG_8) || (i_sel == REG_F);
            START_TASK: o_legal = (i_sel inside {LOAD_CONV_WEIGHTS, RUN_CONV, LOAD_INPUT,
                                                 WRITE_TO_MEM, READ_FROM_MEM});
            default:    o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/aether_engine_cmd_encoder.sv
// ---------------------------------------------------------------------------
// aether_engine_cmd_encoder
// Turns accepted host requests into single-cycle 24-bit decoder commands,
// captures READ_REG data at a fixed latency and drops illegal requests.
// Parameters:
//   RdLatency - cycles from READ_REG on cmd_o to valid data_i (1..7)
//   IssueGap  - forced NOP cycles after each issued command (0..15)
// Ports:
//   clk_i, rst_i              - clock, synchronous active-high reset
//   req_valid_i/req_ready_o   - request handshake
//   req_op_i/sel_i/payload_i  - request fields
//   cmd_o                     - registered command to decoder (NOP when idle)
//   buffer_full_i             - decoder back-pressure, blocks acceptance only
//   data_i                    - decoder read data
//   rsp_valid_o/data_o/sel_o  - read response pulse, held data and address
//   err_o                     - pulse when an illegal request is dropped
//   busy_o                    - encoder is waiting on a read or a gap
// ---------------------------------------------------------------------------
module aether_engine_cmd_encoder
    import aether_engine_pkg::*;
#(
    parameter int RdLatency = 1,
    parameter int IssueGap  = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  req_op_i,
    input  logic [3:0]  req_sel_i,
    input  logic [15:0] req_payload_i,
    output logic [23:0] cmd_o,
    input  logic        buffer_full_i,
    input  logic [15:0] data_i,
    output logic        rsp_valid_o,
    output logic [15:0] rsp_data_o,
    output logic [3:0]  rsp_sel_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam logic [3:0] RD_LAT  = 4'(RdLatency);
    localparam logic [3:0] GAP_LEN = 4'(IssueGap);
    localparam bit         HAS_GAP = (IssueGap > 0);

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_count;
    logic [3:0]  w_nextCount;
    cmd_t        r_cmd;
    cmd_t        w_nextCmd;
    logic        r_err;
    logic        w_nextErr;
    logic        r_rspValid;
    logic        w_nextRspValid;
    logic [15:0] r_rspData;
    logic [3:0]  r_rspSel;
    logic [3:0]  r_pendSel;
    logic        w_legal;
    logic        w_handshake;
    logic        w_capture;
    logic        w_latchSel;

    aether_engine_cmd_legal u_legal (
        .i_op    (req_op_i),
        .i_sel   (req_sel_i),
        .o_legal (w_legal)
    );

    assign req_ready_o = (r_state == IDLE) && !buffer_full_i;
    assign busy_o      = (r_state != IDLE);
    assign w_handshake = req_valid_i && req_ready_o;

    // Next-state and next-output decode. Commands and pulses default to NOP/0
    // so every registered command lives for exactly one cycle. The counter is
    // loaded with the read latency or the gap length and counts down; a read
    // samples data_i on the edge that closes its counter==0 cycle.
    always_comb begin
        w_nextState    = r_state;
        w_nextCount    = r_count;
        w_nextCmd      = '0;
        w_nextErr      = 1'b0;
        w_nextRspValid = 1'b0;
        w_capture      = 1'b0;
        w_latchSel     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_handshake) begin
                    if (!w_legal) begin
                        w_nextErr = 1'b1;
                    end else begin
                        w_nextCmd = '{op: req_op_i, sel: req_sel_i, payload: req_payload_i};
                        if (req_op_i == READ_REG) begin
                            w_nextState = RD_WAIT;
                            w_nextCount = RD_LAT;
                            w_latchSel  = 1'b1;
                        end else if (HAS_GAP) begin
                            w_nextState = GAP;
                            w_nextCount = GAP_LEN;
                        end
                    end
                end
            end
            RD_WAIT: begin
                if (r_count == 4'd0) begin
                    w_capture      = 1'b1;
                    w_nextRspValid = 1'b1;
                    if (HAS_GAP) begin
                        w_nextState = GAP;
                        w_nextCount = GAP_LEN;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else begin
                    w_nextCount = r_count - 4'd1;
                end
            end
            GAP: begin
                if (r_count <= 4'd1) begin
                    w_nextState = IDLE;
                    w_nextCount = 4'd0;
                end else begin
                    w_nextCount = r_count - 4'd1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCount = 4'd0;
            end
        endcase
    end

    // State and output registers. Reset drops any read or gap in flight, so
    // an abandoned read never produces a response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_count    <= 4'd0;
            r_cmd      <= '0;
            r_err      <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspData  <= 16'h0;
            r_rspSel   <= 4'h0;
            r_pendSel  <= 4'h0;
        end else begin
            r_state    <= w_nextState;
            r_count    <= w_nextCount;
            r_cmd      <= w_nextCmd;
            r_err      <= w_nextErr;
            r_rspValid <= w_nextRspValid;
            if (w_latchSel) begin
                r_pendSel <= req_sel_i;
            end
            if (w_capture) begin
                r_rspData <= data_i;
                r_rspSel  <= r_pendSel;
            end
        end
    end

    assign cmd_o       = r_cmd;
    assign err_o       = r_err;
    assign rsp_valid_o = r_rspValid;
    assign rsp_data_o  = r_rspData;
    assign rsp_sel_o   = r_rspSel;

endmodule
